writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Reset is `reset`: synchronous, active-high.
REQ-002 Parameter `REG_AW`, default 3, register-file address width.
REQ-003 Parameter `MEM_AW`, default 4, data-memory address width.
REQ-004 `clk`  in  1  rising-edge clock.
REQ-005 `reset`  in  1  synchronous active-high reset.
REQ-006 `valid_in`  in  1  execute stage presents a completed instruction.
REQ-007 `ready_out`  out  1  stage accepts an instruction this cycle.
REQ-008 `opcode`  in  5  instruction opcode.
REQ-009 `rd`  in  REG_AW  destination register.
REQ-010 `mem_addr`  in  MEM_AW  store address.
REQ-011 `result`  in  16  execute result; [7:0] for 8-bit ops, full width for MUL and DIV.
REQ-012 `zero_flag`, `carry_flag`, `ac_flag`, `parity_flag`  in  1 each  execute flags.
REQ-013 `mem_ack`  in  1  data memory accepted the write.
REQ-014 `reg_we`  out  1  register-file write strobe.
REQ-015 `reg_waddr`  out  REG_AW  register write address.
REQ-016 `reg_wdata`  out  16  register write data.
REQ-017 `mem_we`  out  1  memory write request.
REQ-018 `mem_waddr`  out  MEM_AW  memory write address.
REQ-019 `mem_wdata`  out  8  memory write data.
REQ-020 `psw`  out  4  architectural flags {parity, ac, carry, zero}.
REQ-021 `halted`  out  1  processor halted.
REQ-022 `retired`  out  8  retired-instruction counter.

Function
REQ-023 Accept: an instruction is captured on a rising edge with `valid_in` && `ready_out`; inputs are ignored otherwise.
REQ-024 FSM states:
- IDLE: `ready_out`=1.
- STORE_WAIT: `ready_out`=0.
- HALTED: `ready_out`=0.
REQ-025 Register-writing opcodes are 00000–01011 and 10000–10101: `reg_we`=1 for exactly one cycle after acceptance; `reg_waddr`=`rd`; `reg_wdata`=`result`, with [15:8] forced to 0 except for MUL (00011) and DIV (00100).
REQ-026 Store (01100): the cycle after acceptance `mem_we`=1, `mem_waddr`=`mem_addr`, `mem_wdata`=`result[7:0]`, and the FSM enters STORE_WAIT.
REQ-027 In STORE_WAIT, `mem_we` and its address/data are held until `mem_ack` is sampled high; `mem_we` is 0 the following cycle and the FSM returns to IDLE.
REQ-028 A `mem_ack` seen while `mem_we`=0 is ignored.
REQ-029 The PSW loads all four input flags on acceptance of opcodes 00001–01010, 10000–10101 and 11001; all other opcodes leave the PSW unchanged.
REQ-030 Compare (11001) updates the PSW only and performs no register write.
REQ-031 Jump/branch (01101, 01110, 10110, 10111, 11000) and undefined opcodes retire with no write and no PSW change.
REQ-032 Halt (11111): on acceptance the FSM enters HALTED and `halted`=1 from the next cycle; HALTED is left only by `reset`.
REQ-033 `retired` increments by 1 when an instruction completes: at acceptance for non-store opcodes, at the `mem_ack` cycle for stores. It wraps 255→0.
REQ-034 Back-to-back accepts in consecutive cycles each produce one `reg_we` pulse, giving a sustained throughput of 1 instruction per cycle.
REQ-035 `reset` during STORE_WAIT abandons the store: `mem_we`=0 the next cycle and no retirement is counted.

Reset
REQ-036 On `reset`, all of the following take effect the next cycle:
- FSM → IDLE.
- `reg_we`, `mem_we`, `halted` = 0.
- `reg_waddr`, `reg_wdata`, `mem_waddr`, `mem_wdata` = 0.
- `psw` = 0000; `retired` = 0.
- `ready_out` = 1.
REQ-037 `reset` has priority over every other event in the same cycle.

Structure
REQ-038 Opcode constants, the FSM state enumeration and the PSW bit positions are defined in the shared CPU package, shared with the execute stage.
REQ-039 A single sub-module, `wb_decode`, is combinational. It maps `opcode` to {writes_reg, is_store, updates_psw, is_halt, wide_result}.

Verification
REQ-040 ADD: opcode 00001, rd=3, result=0x00A5, carry=1, zero=0, ac=1, parity=0 → one cycle later `reg_we`=1, `reg_waddr`=3, `reg_wdata`=0x00A5, `psw`=0110, `retired`=1.
REQ-041 MUL: opcode 00011, result=0x1234 → `reg_wdata`=0x1234. MOV (00000) with result=0xFF07 → `reg_wdata`=0x0007 and `psw` unchanged.
REQ-042 Store: opcode 01100, mem_addr=9, result=0x3C, with `mem_ack` held low 3 cycles → `mem_we`=1, `mem_waddr`=9, `mem_wdata`=0x3C for 4 cycles; `ready_out`=0 throughout; `retired` increments on the ack cycle.
REQ-043 Halt: accept 11111, then hold `valid_in`=1 with ADD → `halted`=1, `ready_out`=0, no `reg_we`; `reset` then returns IDLE with `retired`=0.
REQ-044 Counter wrap: 256 consecutive ADDs → `retired` goes 255→0, with 256 `reg_we` pulses.
REQ-045 Reset mid-store: `reset` asserted on the second STORE_WAIT cycle → `mem_we`=0 the next cycle, `retired` unchanged at 0, `ready_out`=1.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared CPU definitions: opcode map, writeback FSM states, PSW bit positions.
package writeback_stage_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_MOV       = 5'b00000;
    localparam opcode_t OP_ADD       = 5'b00001;
    localparam opcode_t OP_MUL       = 5'b00011;
    localparam opcode_t OP_DIV       = 5'b00100;
    localparam opcode_t OP_PSW_LAST  = 5'b01010;
    localparam opcode_t OP_REG_LAST  = 5'b01011;
    localparam opcode_t OP_STORE     = 5'b01100;
    localparam opcode_t OP_JMP       = 5'b01101;
    localparam opcode_t OP_BR        = 5'b01110;
    localparam opcode_t OP_EXT_FIRST = 5'b10000;
    localparam opcode_t OP_EXT_LAST  = 5'b10101;
    localparam opcode_t OP_JC        = 5'b10110;
    localparam opcode_t OP_JZ        = 5'b10111;
    localparam opcode_t OP_CALL      = 5'b11000;
    localparam opcode_t OP_CMP       = 5'b11001;
    localparam opcode_t OP_HALT      = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_HALTED     = 2'd2
    } wb_state_e;

    localparam int unsigned PSW_ZERO   = 0;
    localparam int unsigned PSW_CARRY  = 1;
    localparam int unsigned PSW_AC     = 2;
    localparam int unsigned PSW_PARITY = 3;

    typedef struct packed {
        logic writes_reg;
        logic is_store;
        logic updates_psw;
        logic is_halt;
        logic wide_result;
    } wb_ctrl_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Execute-to-writeback bus plus the register-file / data-memory write ports.
interface writeback_stage_if #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned MEM_AW = 4
);
    logic              valid_in;
    logic              ready_out;
    logic [4:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       result;
    logic              zero_flag;
    logic              carry_flag;
    logic              ac_flag;
    logic              parity_flag;
    logic              mem_ack;
    logic              reg_we;
    logic [REG_AW-1:0] reg_waddr;
    logic [15:0]       reg_wdata;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [3:0]        psw;
    logic              halted;
    logic [7:0]        retired;

    modport master (
        output valid_in, opcode, rd, mem_addr, result,
               zero_flag, carry_flag, ac_flag, parity_flag, mem_ack,
        input  ready_out, reg_we, reg_waddr, reg_wdata,
               mem_we, mem_waddr, mem_wdata, psw, halted, retired
    );

    modport slave (
        input  valid_in, opcode, rd, mem_addr, result,
               zero_flag, carry_flag, ac_flag, parity_flag, mem_ack,
        output ready_out, reg_we, reg_waddr, reg_wdata,
               mem_we, mem_waddr, mem_wdata, psw, halted, retired
    );
endinterface

// File: rtl/writeback_stage_wb_decode.sv
// Combinational opcode classifier for the writeback stage.
module wb_decode
    import writeback_stage_pkg::*;
(
    input  logic [4:0] i_opcode,
    output wb_ctrl_t   o_ctrl
);

    // Map each opcode onto the writeback actions it triggers.
    always_comb begin
        o_ctrl             = '0;
        o_ctrl.writes_reg  = (i_opcode <= OP_REG_LAST) ||
                             ((i_opcode >= OP_EXT_FIRST) && (i_opcode <= OP_EXT_LAST));
        o_ctrl.is_store    = (i_opcode == OP_STORE);
        o_ctrl.updates_psw = ((i_opcode >= OP_ADD) && (i_opcode <= OP_PSW_LAST)) ||
                             ((i_opcode >= OP_EXT_FIRST) && (i_opcode <= OP_EXT_LAST)) ||
                             (i_opcode == OP_CMP);
        o_ctrl.is_halt     = (i_opcode == OP_HALT);
        o_ctrl.wide_result = (i_opcode == OP_MUL) || (i_opcode == OP_DIV);
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires instructions into the register file, data memory and PSW.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned MEM_AW = 4
) (
    input logic              clk,
    input logic              reset,
    writeback_stage_if.slave wb
);

    wb_state_e         r_state;
    wb_state_e         w_next_state;
    wb_ctrl_t          w_ctrl;
    logic              w_ready;
    logic              w_accept;
    logic              w_store_done;

    logic              r_reg_we;
    logic [REG_AW-1:0] r_reg_waddr;
    logic [15:0]       r_reg_wdata;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_waddr;
    logic [7:0]        r_mem_wdata;
    logic [3:0]        r_psw;
    logic [7:0]        r_retired;

    wb_decode u_decode (
        .i_opcode (wb.opcode),
        .o_ctrl   (w_ctrl)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, handshake and store-completion decode.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_store_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready  = 1'b1;
                w_accept = wb.valid_in;
                if (wb.valid_in) begin
                    if (w_ctrl.is_halt) begin
                        w_next_state = ST_HALTED;
                    end else if (w_ctrl.is_store) begin
                        w_next_state = ST_STORE_WAIT;
                    end
                end
            end
            ST_STORE_WAIT: begin
                w_store_done = wb.mem_ack;
                if (wb.mem_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Write strobes, write payloads, PSW and retirement counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_we    <= 1'b0;
            r_reg_waddr <= '0;
            r_reg_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_psw       <= '0;
            r_retired   <= '0;
        end else begin
            r_reg_we <= 1'b0;
            if (w_accept && w_ctrl.writes_reg) begin
                r_reg_we    <= 1'b1;
                r_reg_waddr <= wb.rd;
                r_reg_wdata <= w_ctrl.wide_result ? wb.result : {8'h00, wb.result[7:0]};
            end
            if (w_accept && w_ctrl.is_store) begin
                r_mem_we    <= 1'b1;
                r_mem_waddr <= wb.mem_addr;
                r_mem_wdata <= wb.result[7:0];
            end else if (w_store_done) begin
                r_mem_we <= 1'b0;
            end
            if (w_accept && w_ctrl.updates_psw) begin
                r_psw[PSW_ZERO]   <= wb.zero_flag;
                r_psw[PSW_CARRY]  <= wb.carry_flag;
                r_psw[PSW_AC]     <= wb.ac_flag;
                r_psw[PSW_PARITY] <= wb.parity_flag;
            end
            if ((w_accept && !w_ctrl.is_store) || w_store_done) begin
                r_retired <= r_retired + 8'd1;
            end
        end
    end

    assign wb.ready_out = w_ready;
    assign wb.reg_we    = r_reg_we;
    assign wb.reg_waddr = r_reg_waddr;
    assign wb.reg_wdata = r_reg_wdata;
    assign wb.mem_we    = r_mem_we;
    assign wb.mem_waddr = r_mem_waddr;
    assign wb.mem_wdata = r_mem_wdata;
    assign wb.psw       = r_psw;
    assign wb.halted    = (r_state == ST_HALTED);
    assign wb.retired   = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: randomized plus directed instruction streams.
module tb_writeback_stage;

    localparam int unsigned RAW = 3;
    localparam int unsigned MAW = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    writeback_stage_if #(.REG_AW(RAW), .MEM_AW(MAW)) wb();

    writeback_stage #(.REG_AW(RAW), .MEM_AW(MAW)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb.slave)
    );

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
    } reg_exp_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } mem_exp_t;

    reg_exp_t reg_q[$];
    mem_exp_t mem_q[$];

    int n_vec    = 0;
    int n_bad    = 0;
    int n_pulses = 0;

    // Reference model: architectural state after the most recent clock edge.
    logic [3:0] m_psw;
    logic [7:0] m_retired;
    bit         m_busy;
    bit         m_halted;
    bit         m_known;
    bit         m_after_reset;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check visible state, drive inputs, advance the model past the next edge.
    // fl is {parity, ac, carry, zero}.
    task automatic cycle(input bit v, input logic [4:0] op, input logic [2:0] rd,
                         input logic [3:0] ma, input logic [15:0] res, input logic [3:0] fl,
                         input bit ack, input bit rst);
        logic [15:0] wd;
        if (m_known) begin
            check("ready_out", wb.ready_out, 32'(!m_busy && !m_halted));
            check("psw", wb.psw, m_psw);
            check("retired", wb.retired, m_retired);
            check("halted", wb.halted, m_halted);
            check("mem_we", wb.mem_we, m_busy);
            if (m_after_reset) begin
                check("rst_reg_we", wb.reg_we, 0);
                check("rst_reg_waddr", wb.reg_waddr, 0);
                check("rst_reg_wdata", wb.reg_wdata, 0);
                check("rst_mem_waddr", wb.mem_waddr, 0);
                check("rst_mem_wdata", wb.mem_wdata, 0);
            end
        end
        reset          = rst;
        wb.valid_in    = v;
        wb.opcode      = op;
        wb.rd          = rd;
        wb.mem_addr    = ma;
        wb.result      = res;
        wb.zero_flag   = fl[0];
        wb.carry_flag  = fl[1];
        wb.ac_flag     = fl[2];
        wb.parity_flag = fl[3];
        wb.mem_ack     = ack;
        m_after_reset  = 1'b0;
        if (rst) begin
            m_known       = 1'b1;
            m_psw         = '0;
            m_retired     = '0;
            m_busy        = 1'b0;
            m_halted      = 1'b0;
            m_after_reset = 1'b1;
        end else if (m_known) begin
            if (m_busy) begin
                if (ack) begin
                    m_busy = 1'b0;
                    m_retired++;
                end
            end else if (!m_halted && v) begin
                if (op inside {[0:11], [16:21]}) begin
                    wd = (op == 5'd3 || op == 5'd4) ? res : {8'h00, res[7:0]};
                    reg_q.push_back(reg_exp_t'({rd, wd}));
                end
                if (op inside {[1:10], [16:21], 25}) m_psw = fl;
                if (op == 5'd12) begin
                    m_busy = 1'b1;
                    mem_q.push_back(mem_exp_t'({ma, res[7:0]}));
                end else begin
                    m_retired++;
                end
                if (op == 5'd31) m_halted = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0, 0, 0);
    endtask

    // Monitor: pops expected writes whenever the DUT presents a write strobe.
    initial begin
        reg_exp_t e;
        bit prev_mem;
        prev_mem = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wb.reg_we === 1'b1) begin
                n_pulses++;
                if (reg_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL reg_we_unexpected: got reg_we=1 waddr=%0d expected no write at %0t",
                             wb.reg_waddr, $time);
                end else begin
                    e = reg_q.pop_front();
                    check("reg_waddr", wb.reg_waddr, e.rd);
                    check("reg_wdata", wb.reg_wdata, e.data);
                end
            end
            if (wb.mem_we === 1'b1) begin
                if (mem_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL mem_we_unexpected: got mem_we=1 expected no store at %0t", $time);
                end else begin
                    check("mem_waddr", wb.mem_waddr, mem_q[0].addr);
                    check("mem_wdata", wb.mem_wdata, mem_q[0].data);
                end
            end else if (prev_mem && mem_q.size() > 0) begin
                void'(mem_q.pop_front());
            end
            prev_mem = (wb.mem_we === 1'b1);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios and a randomized stream.
    initial begin
        bit          rv;
        bit          rr;
        logic [4:0]  rop;
        int          p0;

        m_known = 1'b0;
        reset = 1'b1;
        wb.valid_in = 1'b0;
        wb.opcode = '0;
        wb.rd = '0;
        wb.mem_addr = '0;
        wb.result = '0;
        wb.zero_flag = 1'b0;
        wb.carry_flag = 1'b0;
        wb.ac_flag = 1'b0;
        wb.parity_flag = 1'b0;
        wb.mem_ack = 1'b0;
        @(negedge clk);

        cycle(0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0, 0, 1);
        cycle(0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0, 0, 1);
        idle(1);

        // ADD rd=3 result=A5 with carry and ac set.
        cycle(1, 5'b00001, 3'd3, 4'd0, 16'h00A5, 4'b0110, 0, 0);
        check("add_psw", wb.psw, 4'b0110);
        check("add_retired", wb.retired, 1);
        // MUL keeps the high byte; MOV clears it and leaves the PSW alone.
        cycle(1, 5'b00011, 3'd2, 4'd0, 16'h1234, 4'b1001, 0, 0);
        cycle(1, 5'b00000, 3'd5, 4'd0, 16'hFF07, 4'b0110, 0, 0);
        check("mov_psw", wb.psw, 4'b1001);
        cycle(1, 5'b11001, 3'd1, 4'd0, 16'hBEEF, 4'b0011, 0, 0);
        cycle(1, 5'b01101, 3'd1, 4'd0, 16'hBEEF, 4'b1100, 0, 0);
        idle(1);

        // Store with ack held low for three cycles; valid ADD offered meanwhile.
        cycle(1, 5'b01100, 3'd0, 4'd9, 16'h003C, 4'h0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 5'b00001, 3'd4, 4'd0, 16'h0011, 4'hF, 0, 0);
        cycle(1, 5'b00001, 3'd4, 4'd0, 16'h0011, 4'hF, 1, 0);
        idle(1);

        // Randomized stream.
        for (int i = 0; i < 3000; i++) begin
            rv  = ($urandom_range(0, 2) != 0);
            rop = 5'($urandom_range(0, 31));
            if (rop == 5'd31 && $urandom_range(0, 7) != 0) rop = 5'd1;
            rr  = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
            cycle(rv, rop, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  16'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0, rr);
        end
        idle(2);

        // Halt, then keep offering ADDs; only reset leaves HALTED.
        cycle(0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0, 0, 1);
        cycle(1, 5'b11111, 3'd0, 4'd0, 16'h0, 4'h0, 0, 0);
        check("halt_flag", wb.halted, 1);
        for (int i = 0; i < 5; i++) cycle(1, 5'b00001, 3'd6, 4'd0, 16'h0055, 4'hF, 1, 0);
        cycle(1, 5'b00001, 3'd6, 4'd0, 16'h0055, 4'hF, 0, 1);
        check("halt_reset_retired", wb.retired, 0);
        check("halt_reset_ready", wb.ready_out, 1);
        idle(1);

        // 256 back-to-back ADDs wrap the retirement counter.
        p0 = n_pulses;
        for (int i = 0; i < 256; i++)
            cycle(1, 5'b00001, 3'(i), 4'd0, 16'(i), 4'(i), 0, 0);
        idle(1);
        check("wrap_retired", wb.retired, 0);
        check("wrap_pulses", n_pulses - p0, 256);

        // Reset on the second STORE_WAIT cycle abandons the store.
        cycle(0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0, 0, 1);
        cycle(1, 5'b01100, 3'd0, 4'd5, 16'h00C3, 4'h0, 0, 0);
        cycle(0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0, 0, 0);
        cycle(0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0, 0, 1);
        check("abort_mem_we", wb.mem_we, 0);
        check("abort_retired", wb.retired, 0);
        check("abort_ready", wb.ready_out, 1);
        idle(3);

        check("reg_q_drained", reg_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
